commit_monitor: RTL and testbench



---
 rtl/commit_monitor.sv | 121 ++++++++++++
 tb/tb_commit_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_monitor.sv
// Commit-stream monitor: cycle/retire counters, PC continuity check,
// commit watchdog and a circular trace of recently retired PCs.
module commit_monitor #(
  parameter int WATCHDOG_CYCLES = 1000,
  parameter int TRACE_DEPTH     = 8,
  parameter int CNT_W           = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           commit,
  input  logic [31:0]                    commit_pc,
  input  logic [31:0]                    commit_pre_pc,
  input  logic                           trace_rd_en,
  output logic [31:0]                    trace_rd_data,
  output logic                           trace_empty,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic [CNT_W-1:0]               cycle_cnt,
  output logic [CNT_W-1:0]               instr_cnt,
  output logic                           flow_err,
  output logic [31:0]                    flow_err_pc,
  output logic [31:0]                    flow_err_expect,
  output logic                           hang,
  output logic [1:0]                     state_o
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(WATCHDOG_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2,
    HANG = 2'd3
  } state_t;

  state_t          state;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [31:0]     mem [TRACE_DEPTH];
  logic [WW-1:0]   wd_cnt;
  logic [31:0]     exp_pc;

  logic active;
  logic wr;
  logic rd;
  logic full;

  assign active = (state == IDLE) || (state == RUN);
  assign wr     = active && commit;
  assign rd     = trace_rd_en && (count != '0);
  assign full   = (count == CW'(TRACE_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      wd_cnt          <= '0;
      exp_pc          <= '0;
      cycle_cnt       <= '0;
      instr_cnt       <= '0;
      flow_err        <= 1'b0;
      flow_err_pc     <= '0;
      flow_err_expect <= '0;
      hang            <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (commit) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
        exp_pc    <= commit_pre_pc;
      end

      // A write into a full buffer without a pop drops the oldest entry.
      if (wr)
        tail <= tail + AW'(1);
      if (rd || (wr && full))
        head <= head + AW'(1);
      if (wr && !rd && !full)
        count <= count + CW'(1);
      else if (rd && !wr)
        count <= count - CW'(1);

      case (state)
        IDLE, RUN: begin
          if (commit) begin
            wd_cnt <= '0;
            if (state == RUN && commit_pc != exp_pc) begin
              flow_err        <= 1'b1;
              flow_err_pc     <= commit_pc;
              flow_err_expect <= exp_pc;
              state           <= ERR;
            end else begin
              state <= RUN;
            end
          end else if (wd_cnt == WW'(WATCHDOG_CYCLES - 1)) begin
            hang  <= 1'b1;
            state <= HANG;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Storage needs no reset: stale slots are masked by the pointers.
  always_ff @(posedge clk) begin
    if (wr)
      mem[tail] <= commit_pc;
  end

  assign trace_empty   = (count == '0);
  assign trace_count   = count;
  assign trace_rd_data = trace_empty ? 32'd0 : mem[head];
  assign state_o       = state;

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_commit_monitor;

  localparam int WD = 10;
  localparam int D  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit;
  logic [31:0] commit_pc;
  logic [31:0] commit_pre_pc;
  logic        trace_rd_en;
  logic [31:0] trace_rd_data;
  logic        trace_empty;
  logic [3:0]  trace_count;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
  logic        flow_err;
  logic [31:0] flow_err_pc;
  logic [31:0] flow_err_expect;
  logic        hang;
  logic [1:0]  state_o;

  commit_monitor #(
    .WATCHDOG_CYCLES(WD),
    .TRACE_DEPTH(D),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .commit(commit),
    .commit_pc(commit_pc),
    .commit_pre_pc(commit_pre_pc),
    .trace_rd_en(trace_rd_en),
    .trace_rd_data(trace_rd_data),
    .trace_empty(trace_empty),
    .trace_count(trace_count),
    .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt),
    .flow_err(flow_err),
    .flow_err_pc(flow_err_pc),
    .flow_err_expect(flow_err_expect),
    .hang(hang),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int nchk  = 0;

  // Reference model: 0 idle, 1 run, 2 err, 3 hang
  int          m_state;
  logic [31:0] m_cyc, m_ins, m_exp, m_epc, m_eexp;
  bit          m_ferr, m_hang;
  int          m_idle;
  logic [31:0] m_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      npass++;
  endtask

  function automatic void model_step(input bit r, input bit c,
                                     input logic [31:0] pc,
                                     input logic [31:0] pre,
                                     input bit rd);
    bit act;
    if (r) begin
      m_state = 0; m_cyc = 0; m_ins = 0; m_exp = 0;
      m_epc = 0; m_eexp = 0; m_ferr = 0; m_hang = 0;
      m_idle = 0; m_q.delete();
      return;
    end
    act = (m_state < 2);
    m_cyc++;
    if (c) m_ins++;
    if (rd && m_q.size() > 0) void'(m_q.pop_front());
    if (act && c) begin
      m_q.push_back(pc);
      if (m_q.size() > D) void'(m_q.pop_front());
    end
    if (act) begin
      if (c) begin
        m_idle = 0;
        if (m_state == 1 && pc != m_exp) begin
          m_ferr = 1; m_epc = pc; m_eexp = m_exp; m_state = 2;
        end else begin
          m_state = 1;
        end
      end else begin
        m_idle++;
        if (m_idle == WD) begin
          m_hang = 1; m_state = 3;
        end
      end
    end
    if (c) m_exp = pre;
  endfunction

  task automatic cmp_all();
    chk("state", 32'(state_o), 32'(m_state));
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("instr_cnt", instr_cnt, m_ins);
    chk("flow_err", 32'(flow_err), 32'(m_ferr));
    chk("flow_err_pc", flow_err_pc, m_epc);
    chk("flow_err_expect", flow_err_expect, m_eexp);
    chk("hang", 32'(hang), 32'(m_hang));
    chk("trace_count", 32'(trace_count), 32'(m_q.size()));
    chk("trace_empty", 32'(trace_empty), 32'(m_q.size() == 0));
    chk("trace_rd_data", trace_rd_data,
        (m_q.size() > 0) ? m_q[0] : 32'd0);
  endtask

  task automatic tick(input bit r, input bit c, input logic [31:0] pc,
                      input logic [31:0] pre, input bit rd);
    rst = r; commit = c; commit_pc = pc;
    commit_pre_pc = pre; trace_rd_en = rd;
    model_step(r, c, pc, pre, rd);
    @(posedge clk);
    @(negedge clk);
    cmp_all();
  endtask

  typedef struct {
    bit          r;
    bit          c;
    logic [31:0] pc;
    logic [31:0] pre;
    bit          rd;
    logic [1:0]  st;
    logic [31:0] ins;
    logic [3:0]  cnt;
    logic [31:0] data;
    bit          fe;
  } vec_t;

  vec_t vecs[12];

  initial begin
    rst = 1'b1; commit = 1'b0; commit_pc = '0;
    commit_pre_pc = '0; trace_rd_en = 1'b0;
    @(negedge clk);

    vecs[0]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'd0, 4'd0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'd0, 4'd0, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h80000000, 32'h80000004, 1'b0,
                 2'd1, 32'd1, 4'd1, 32'h80000000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h80000004, 32'h80000008, 1'b0,
                 2'd1, 32'd2, 4'd2, 32'h80000000, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h80000008, 32'h8000000C, 1'b0,
                 2'd1, 32'd3, 4'd3, 32'h80000000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'd0, 4'd0, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h100, 32'h104, 1'b0, 2'd1, 32'd1, 4'd1, 32'h100, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h200, 32'h204, 1'b0, 2'd2, 32'd2, 4'd2, 32'h100, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'h204, 32'h208, 1'b0, 2'd2, 32'd3, 4'd2, 32'h100, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h208, 32'h20C, 1'b0, 2'd2, 32'd4, 4'd2, 32'h100, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h20C, 32'h210, 1'b0, 2'd2, 32'd5, 4'd2, 32'h100, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'd0, 4'd0, 32'h0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].r, vecs[i].c, vecs[i].pc, vecs[i].pre, vecs[i].rd);
      chk("vec_state", 32'(state_o), 32'(vecs[i].st));
      chk("vec_instr", instr_cnt, vecs[i].ins);
      chk("vec_count", 32'(trace_count), 32'(vecs[i].cnt));
      chk("vec_data", trace_rd_data, vecs[i].data);
      chk("vec_flow", 32'(flow_err), 32'(vecs[i].fe));
      if (i == 10) begin
        chk("vec_err_pc", flow_err_pc, 32'h200);
        chk("vec_err_exp", flow_err_expect, 32'h104);
      end
      if (i == 11) begin
        chk("rst_empty", 32'(trace_empty), 32'd1);
        chk("rst_cycle", cycle_cnt, 32'd0);
        chk("rst_err_pc", flow_err_pc, 32'd0);
      end
    end
    // First commit after reset is accepted unchecked
    tick(1'b0, 1'b1, 32'h500, 32'h504, 1'b0);
    chk("post_rst_state", 32'(state_o), 32'd1);
    chk("post_rst_flow", 32'(flow_err), 32'd0);

    // Watchdog
    tick(1'b1, 1'b0, 0, 0, 1'b0);
    tick(1'b0, 1'b1, 32'h0, 32'h4, 1'b0);
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b0, 0, 0, 1'b0);
    chk("wd_9idle", 32'(hang), 32'd0);
    tick(1'b0, 1'b1, 32'h4, 32'h8, 1'b0);
    chk("wd_save_hang", 32'(hang), 32'd0);
    chk("wd_save_state", 32'(state_o), 32'd1);
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b0, 0, 0, 1'b0);
    chk("wd_pre_exp", 32'(hang), 32'd0);
    tick(1'b0, 1'b0, 0, 0, 1'b0);
    chk("wd_hang", 32'(hang), 32'd1);
    chk("wd_state", 32'(state_o), 32'd3);
    tick(1'b0, 1'b1, 32'h8, 32'hC, 1'b0);
    chk("wd_frozen_cnt", 32'(trace_count), 32'd2);

    // Trace overflow
    tick(1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 11; i++)
      tick(1'b0, 1'b1, 32'(4 * i), 32'(4 * i + 4), 1'b0);
    chk("ovf_count", 32'(trace_count), 32'd8);
    chk("ovf_head", trace_rd_data, 32'h0C);
    for (int k = 0; k < 8; k++) begin
      chk("ovf_pop", trace_rd_data, 32'(32'h0C + 4 * k));
      tick(1'b0, 1'b0, 0, 0, 1'b1);
    end
    chk("ovf_empty", 32'(trace_empty), 32'd1);
    tick(1'b0, 1'b0, 0, 0, 1'b1);
    chk("rd_empty_cnt", 32'(trace_count), 32'd0);

    // Simultaneous read/write
    tick(1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      tick(1'b0, 1'b1, 32'(4 * i), 32'(4 * i + 4), 1'b0);
    tick(1'b0, 1'b1, 32'h20, 32'h24, 1'b1);
    chk("rw_full_cnt", 32'(trace_count), 32'd8);
    chk("rw_full_head", trace_rd_data, 32'h4);
    for (int k = 0; k < 8; k++) begin
      chk("rw_pop", trace_rd_data, 32'(4 * (k + 1)));
      tick(1'b0, 1'b0, 0, 0, 1'b1);
    end
    tick(1'b0, 1'b1, 32'h24, 32'h28, 1'b1);
    chk("rw_empty_cnt", 32'(trace_count), 32'd1);
    chk("rw_empty_data", trace_rd_data, 32'h24);

    // Randomized traffic
    for (int seg = 0; seg < 9; seg++) begin
      int prob;
      prob = (seg % 3 == 0) ? 90 : (seg % 3 == 1) ? 60 : 15;
      tick(1'b1, 1'b0, 0, 0, 1'b0);
      for (int n = 0; n < 150; n++) begin
        bit          c, rd, r;
        logic [31:0] pc, pre;
        r   = ($urandom_range(199) == 0);
        c   = ($urandom_range(99) < prob);
        pc  = ($urandom_range(39) == 0) ? $urandom : m_exp;
        pre = ($urandom_range(7) == 0) ? $urandom : pc + 32'd4;
        rd  = ($urandom_range(2) == 0);
        tick(r, c, pc, pre, rd);
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
